// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared types and default parameter values for the PC sequencer.
//   pc_sel_t    next-PC source selector
//   DEF_*       default values for the pc_sequencer / pc_ras parameters
package pc_seq_pkg;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_REL = 2'd1,
        SEL_REG = 2'd2,
        SEL_RAS = 2'd3
    } pc_sel_t;

    localparam int unsigned       DEF_PC_W       = 64;
    localparam int unsigned       DEF_INST_BYTES = 4;
    localparam int unsigned       DEF_IMM_SHIFT  = 2;
    localparam int unsigned       DEF_RAS_DEPTH  = 4;
    localparam logic [63:0]       DEF_RESET_PC   = 64'h0;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack.
//   clk, rst_n  clock, asynchronous active-low reset (discards all entries)
//   push        write push_data as the new top (overwrites oldest when full)
//   pop         drop the top entry; ignored when empty
//   push_data   value to push
//   top         current top entry (undefined when empty)
//   empty       registered, high when the stack holds no entries
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned W     = DEF_PC_W,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             do_pop;

    assign do_pop = pop && (cnt != '0);
    assign top    = mem[ptr];

    // Pointer/count update; push+pop replaces the top entry in place.
    always_comb begin
        ptr_nxt = ptr;
        cnt_nxt = cnt;
        if (push && do_pop) begin
            ptr_nxt = ptr;
            cnt_nxt = cnt;
        end else if (push) begin
            ptr_nxt = ptr + PTR_W'(1);
            if (cnt != CNT_W'(DEPTH)) begin
                cnt_nxt = cnt + CNT_W'(1);
            end
        end else if (do_pop) begin
            ptr_nxt = ptr - PTR_W'(1);
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    // Control state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr   <= '0;
            cnt   <= '0;
            empty <= 1'b1;
        end else begin
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
            empty <= (cnt_nxt == '0);
        end
    end

    // Entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_nxt] <= push_data;
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered program counter with next-PC selection.
// Optional return-address stack enabled by defining PC_SEQ_RAS_EN; when
// undefined, Ret acts as BranchReg, Link is ignored and RasEmpty is tied 1.
//   CLK, Reset_L   clock, asynchronous active-low reset
//   Stall          hold PC and suppress stack updates
//   Branch/ALUZero conditional PC-relative branch
//   Uncondbranch   unconditional PC-relative branch
//   BranchReg      register-indirect branch to RegTarget
//   Link / Ret     call (push SeqPC) / return (pop stack)
//   SignExtImm     branch offset in instruction units
//   RegTarget      register branch target
//   CurrentPC      registered PC
//   NextPC, Taken  combinational next PC and non-sequential flag
//   RasEmpty       registered stack-empty flag
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned      PC_W       = DEF_PC_W,
    parameter int unsigned      INST_BYTES = DEF_INST_BYTES,
    parameter int unsigned      IMM_SHIFT  = DEF_IMM_SHIFT,
    parameter logic [PC_W-1:0]  RESET_PC   = PC_W'(DEF_RESET_PC),
    parameter int unsigned      RAS_DEPTH  = DEF_RAS_DEPTH
) (
    input  logic            CLK,
    input  logic            Reset_L,
    input  logic            Stall,
    input  logic            Branch,
    input  logic            ALUZero,
    input  logic            Uncondbranch,
    input  logic            BranchReg,
    input  logic            Link,
    input  logic            Ret,
    input  logic [PC_W-1:0] SignExtImm,
    input  logic [PC_W-1:0] RegTarget,
    output logic [PC_W-1:0] CurrentPC,
    output logic [PC_W-1:0] NextPC,
    output logic            Taken,
    output logic            RasEmpty
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] rel_pc;
    logic [PC_W-1:0] ras_top;
    logic            ras_empty;
    pc_sel_t         sel;

    assign seq_pc = CurrentPC + PC_W'(INST_BYTES);
    assign rel_pc = CurrentPC + (SignExtImm << IMM_SHIFT);

`ifdef PC_SEQ_RAS_EN
    pc_ras #(
        .W     (PC_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst_n     (Reset_L),
        .push      (Link && !Stall),
        .pop       (Ret && !Stall),
        .push_data (seq_pc),
        .top       (ras_top),
        .empty     (ras_empty)
    );
`else
    // No stack: Ret always falls through to the register target.
    assign ras_top   = '0;
    assign ras_empty = 1'b1;
    logic unused_ras;
    assign unused_ras = &{1'b0, Link, RAS_DEPTH[0]};
`endif

    assign RasEmpty = ras_empty;

    // Fixed-priority source select.
    always_comb begin
        sel = SEL_SEQ;
        if (Ret && !ras_empty) begin
            sel = SEL_RAS;
        end else if (Ret || BranchReg) begin
            sel = SEL_REG;
        end else if (Uncondbranch || (Branch && ALUZero)) begin
            sel = SEL_REL;
        end
    end

    always_comb begin
        NextPC = seq_pc;
        case (sel)
            SEL_REL: NextPC = rel_pc;
            SEL_REG: NextPC = RegTarget;
            SEL_RAS: NextPC = ras_top;
            default: NextPC = seq_pc;
        endcase
    end

    assign Taken = (sel != SEL_SEQ);

    // Architectural PC.
    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            CurrentPC <= RESET_PC;
        end else if (!Stall) begin
            CurrentPC <= NextPC;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
// Expected post-edge PC/RasEmpty values are queued when a step is driven and
// popped after the clock edge. Stack-specific steps follow PC_SEQ_RAS_EN.
module tb_pc_sequencer;

    logic        CLK;
    logic        Reset_L;
    logic        Stall;
    logic        Branch;
    logic        ALUZero;
    logic        Uncondbranch;
    logic        BranchReg;
    logic        Link;
    logic        Ret;
    logic [63:0] SignExtImm;
    logic [63:0] RegTarget;
    logic [63:0] CurrentPC;
    logic [63:0] NextPC;
    logic        Taken;
    logic        RasEmpty;

    typedef struct {
        string       tag;
        logic [63:0] pc;
        logic        empty;
    } exp_t;

    exp_t exp_q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    pc_sequencer #(
        .PC_W       (64),
        .INST_BYTES (4),
        .IMM_SHIFT  (2),
        .RESET_PC   (64'h100),
        .RAS_DEPTH  (4)
    ) dut (
        .CLK          (CLK),
        .Reset_L      (Reset_L),
        .Stall        (Stall),
        .Branch       (Branch),
        .ALUZero      (ALUZero),
        .Uncondbranch (Uncondbranch),
        .BranchReg    (BranchReg),
        .Link         (Link),
        .Ret          (Ret),
        .SignExtImm   (SignExtImm),
        .RegTarget    (RegTarget),
        .CurrentPC    (CurrentPC),
        .NextPC       (NextPC),
        .Taken        (Taken),
        .RasEmpty     (RasEmpty)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic ctl(input logic br, input logic z, input logic ub, input logic breg,
                       input logic lnk, input logic ret, input logic stl,
                       input logic [63:0] imm, input logic [63:0] rt);
        Branch = br; ALUZero = z; Uncondbranch = ub; BranchReg = breg;
        Link = lnk; Ret = ret; Stall = stl; SignExtImm = imm; RegTarget = rt;
    endtask

    // Combinational check of NextPC/Taken against current inputs.
    task automatic peek(input string tag, input logic [63:0] exp_next, input logic exp_taken);
        #1;
        check({tag, ".next"}, NextPC, exp_next);
        check({tag, ".taken"}, 64'(Taken), 64'(exp_taken));
    endtask

    // One clocked step: queue the expected post-edge state, edge, pop and compare.
    task automatic step(input string tag, input logic [63:0] exp_next, input logic exp_taken,
                        input logic [63:0] exp_pc, input logic exp_empty);
        exp_t e;
        peek(tag, exp_next, exp_taken);
        e.tag = tag; e.pc = exp_pc; e.empty = exp_empty;
        exp_q.push_back(e);
        @(posedge CLK);
        #1;
        if (exp_q.size() == 0) begin
            check({tag, ".queue"}, 64'(0), 64'(1));
        end else begin
            e = exp_q.pop_front();
            check({e.tag, ".pc"}, CurrentPC, e.pc);
            check({e.tag, ".empty"}, 64'(RasEmpty), 64'(e.empty));
        end
    endtask

    initial begin
        Reset_L = 1'b0;
        ctl(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        #12;
        check("rst.pc", CurrentPC, 64'h100);
        check("rst.empty", 64'(RasEmpty), 64'(1'b1));
        check("rst.next", NextPC, 64'h104);
        check("rst.taken", 64'(Taken), 64'(1'b0));
        Reset_L = 1'b1;

        // Sequential fetch from reset vector
        step("seq0", 64'h104, 1'b0, 64'h104, 1'b1);
        step("seq1", 64'h108, 1'b0, 64'h108, 1'b1);
        step("seq2", 64'h10C, 1'b0, 64'h10C, 1'b1);

        // Register branch to 0x200, then conditional branch both ways
        ctl(0, 0, 0, 1, 0, 0, 0, 64'h0, 64'h200);
        step("breg", 64'h200, 1'b1, 64'h200, 1'b1);
        ctl(1, 1, 0, 0, 0, 0, 0, -64'sd2, 64'h0);
        peek("cbz_taken", 64'h1F8, 1'b1);
        ctl(1, 0, 0, 0, 0, 0, 0, -64'sd2, 64'h0);
        step("cbz_not", 64'h204, 1'b0, 64'h204, 1'b1);

        // Unconditional relative, and BranchReg outranks it
        ctl(0, 0, 1, 0, 0, 0, 0, 64'h10, 64'h0);
        step("uncond", 64'h244, 1'b1, 64'h244, 1'b1);
        ctl(1, 1, 1, 1, 0, 0, 0, 64'h10, 64'hFFFF_FFFF_FFFF_FFFC);
        step("prio_reg", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);

        // Wrap, then stall holds PC with Link asserted
        ctl(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        step("wrap", 64'h0, 1'b0, 64'h0, 1'b1);
        ctl(0, 0, 0, 0, 1, 0, 1, 64'h0, 64'h0);
        step("stall0", 64'h4, 1'b0, 64'h0, 1'b1);
        step("stall1", 64'h4, 1'b0, 64'h0, 1'b1);
        ctl(0, 0, 0, 1, 1, 0, 1, 64'h0, 64'h50);
        step("stall2", 64'h50, 1'b1, 64'h0, 1'b1);
        ctl(0, 0, 1, 0, 0, 0, 0, -64'sd1, 64'h0);
        step("neg_wrap", 64'hFFFF_FFFF_FFFF_FFFC, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);

`ifdef PC_SEQ_RAS_EN
        // BL / RET pair
        ctl(0, 0, 0, 1, 0, 0, 0, 64'h0, 64'h300);
        step("to300", 64'h300, 1'b1, 64'h300, 1'b1);
        ctl(0, 0, 1, 0, 1, 0, 0, 64'h40, 64'h0);
        step("bl", 64'h400, 1'b1, 64'h400, 1'b0);
        ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'hDEAD);
        step("ret", 64'h304, 1'b1, 64'h304, 1'b1);

        // Five nested calls into a depth-4 stack
        ctl(0, 0, 0, 1, 0, 0, 0, 64'h0, 64'hC);
        step("toC", 64'hC, 1'b1, 64'hC, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            logic [63:0] tgt;
            tgt = (i == 5) ? 64'h1000 : 64'((i + 1) * 16 - 4);
            ctl(0, 0, 0, 1, 1, 0, 0, 64'h0, tgt);
            step($sformatf("call%0d", i), tgt, 1'b1, tgt, 1'b0);
        end
        for (int i = 5; i >= 2; i--) begin
            logic [63:0] ra;
            ra = 64'(i * 16);
            ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h900);
            step($sformatf("ret%0d", i), ra, 1'b1, ra, (i == 2));
        end
        ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h900);
        step("ret_empty", 64'h900, 1'b1, 64'h900, 1'b1);

        // Ret and Link together swap the top entry
        ctl(0, 0, 0, 1, 1, 0, 0, 64'h0, 64'hA00);
        step("call_a", 64'hA00, 1'b1, 64'hA00, 1'b0);
        ctl(0, 0, 0, 0, 1, 1, 0, 64'h0, 64'h777);
        step("ret_link", 64'h904, 1'b1, 64'h904, 1'b0);
        ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h777);
        step("ret_swap", 64'hA04, 1'b1, 64'hA04, 1'b1);

        // Leave an entry on the stack for the reset test below
        ctl(0, 0, 0, 1, 1, 0, 0, 64'h0, 64'hB00);
        step("call_b", 64'hB00, 1'b1, 64'hB00, 1'b0);
`else
        // Without the stack, Link is ignored and Ret uses RegTarget
        ctl(0, 0, 0, 1, 1, 0, 0, 64'h0, 64'h600);
        step("link_nop", 64'h600, 1'b1, 64'h600, 1'b1);
        ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h700);
        step("ret_reg", 64'h700, 1'b1, 64'h700, 1'b1);
`endif

        // Asynchronous reset between edges
        ctl(0, 0, 0, 0, 0, 0, 0, 64'h0, 64'h0);
        Reset_L = 1'b0;
        #2;
        check("mid_rst.pc", CurrentPC, 64'h100);
        check("mid_rst.empty", 64'(RasEmpty), 64'(1'b1));
        ctl(0, 0, 0, 0, 0, 1, 0, 64'h0, 64'h800);
        peek("rst_ret", 64'h800, 1'b1);
        Reset_L = 1'b1;
        step("ret_after_rst", 64'h800, 1'b1, 64'h800, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Registered program-counter unit for the LEGv8 datapath, replacing the purely combinational next-PC adder/mux. Holds the architectural PC and selects each cycle between sequential fetch, PC-relative branch (conditional or unconditional), register-indirect branch and, optionally, a return predicted from a small return-address stack (RAS). Sits between the control unit and ALU zero flag on the input side and the instruction memory on the output side.

## Interface
- PC_W, 64, PC and target width in bits
- INST_BYTES, 4, sequential increment; power of two
- IMM_SHIFT, 2, left shift applied to SignExtImm before the add
- RESET_PC, 0, PC value loaded on reset
- RAS_DEPTH, 4, RAS entries; power of two, ≥2 (used only with PC_SEQ_RAS_EN)

- CLK  in  1  rising-edge clock
- Reset_L  in  1  asynchronous, active-low reset
- Stall  in  1  hold PC; suppress all RAS updates
- Branch  in  1  conditional branch (CBZ)
- ALUZero  in  1  ALU zero flag
- Uncondbranch  in  1  unconditional PC-relative branch (B/BL)
- BranchReg  in  1  register-indirect branch (BR)
- Link  in  1  call; push return address (BL)
- Ret  in  1  return; pop RAS
- SignExtImm  in  PC_W  sign-extended branch offset, instruction units
- RegTarget  in  PC_W  register value for BranchReg/Ret
- CurrentPC  out  PC_W  registered PC
- NextPC  out  PC_W  PC to be loaded at next unstalled edge
- Taken  out  1  NextPC is not sequential
- RasEmpty  out  1  RAS holds no entries

## Operation
- SeqPC = CurrentPC + INST_BYTES; RelPC = CurrentPC + (SignExtImm << IMM_SHIFT); both mod 2^PC_W, wrap silently.
- Select priority, highest first: Ret with RAS non-empty → RAS top; Ret with RAS empty, or BranchReg → RegTarget; Uncondbranch → RelPC; Branch & ALUZero → RelPC; else SeqPC.
- Taken = 1 for every selection except SeqPC.
- Link pushes SeqPC (value of the calling instruction + INST_BYTES).
- RAS is circular: push when full overwrites the oldest entry, count stays RAS_DEPTH; pop when empty changes nothing.
- Ret and Link together: top is used as target and popped, then SeqPC pushed; count unchanged.
- Stall=1: CurrentPC holds, no push/pop; NextPC and Taken still reflect current inputs.
- Conflicting controls resolved only by priority above; no error flagged.

## Timing
- Reset (Reset_L=0, async): CurrentPC=RESET_PC, RAS count=0, RasEmpty=1; entry contents don't care. NextPC/Taken follow combinationally from reset state.
- Reset deasserted mid-program discards RAS entirely.
- CurrentPC updates to NextPC at each rising CLK with Stall=0 and Reset_L=1: one-cycle latency from control inputs to PC.
- NextPC, Taken combinational from inputs, CurrentPC and RAS top; no registered outputs other than CurrentPC and RasEmpty.
- RAS push/pop take effect at the same edge as the PC update; a Ret in the cycle after a Link returns the just-pushed address.

## Configuration
- PC_SEQ_RAS_EN defined: RAS instantiated as above.
- Undefined: no storage; Ret behaves exactly as BranchReg; Link ignored; RasEmpty tied 1; RAS_DEPTH unused.

## Structure
- Package pc_seq_pkg: enum pc_sel_t {SEL_SEQ, SEL_REL, SEL_REG, SEL_RAS}; default parameter constants.
- Sub-module pc_ras: circular stack with top pointer and count, ports push, pop, push_data, top, empty; instantiated only under PC_SEQ_RAS_EN.
- Top level: adders, priority select, PC register.

## Test plan
- Reset with RESET_PC=0x100, no controls, 3 edges → CurrentPC 0x100, 0x104, 0x108, 0x10C; Taken=0.
- CurrentPC=0x200, Branch=1, ALUZero=1, SignExtImm=-2 → NextPC=0x1F8, Taken=1; ALUZero=0 → NextPC=0x204.
- CurrentPC=0xFFFF_FFFF_FFFF_FFFC, sequential → wraps to 0x0; Stall=1 for 3 edges → PC holds, Link during stall not pushed.
- (RAS_EN) BL at 0x300 (Link, Uncondbranch, Imm=0x40) → PC 0x400; Ret next cycle with RegTarget=0xDEAD → PC 0x304, RasEmpty=1.
- (RAS_EN, depth 4) five nested Links pushing 0x10,0x20,0x30,0x40,0x50 → five Rets return 0x50,0x40,0x30,0x20, then RegTarget.
- Assert Reset_L low between CLK edges after pushes → CurrentPC=RESET_PC immediately, RasEmpty=1; without RAS_EN Ret with RegTarget=0x800 → NextPC=0x800.
